// File: rtl/capture_ctrl.sv
// Capture sequencer: arms the sampler, then replays the circular sample buffer
// in chronological order (starting PRE_SAMPLES before the trigger) to the host link.
module capture_ctrl #(
  parameter logic [7:0] MODULE_ID   = 8'h10,
  parameter int         ADDR_W      = 10,
  parameter int         PRE_SAMPLES = 512,
  parameter int         DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        state,
  input  logic              state_change,
  output logic              arm,
  input  logic              samp_done,
  input  logic [ADDR_W-1:0] trig_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_DONE,
    S_FETCH,
    S_LOAD,
    S_PRESENT,
    S_FINISH
  } fsm_t;

  localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_SAMPLES);
  localparam logic [ADDR_W:0]   LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  fsm_t              fsm_q;
  fsm_t              fsm_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic              sel;
  logic              abort;
  logic              hs;

  assign sel   = state_change && (state == MODULE_ID);
  assign abort = state_change && (state != MODULE_ID);
  assign hs    = tx_valid && tx_ready;

  // Abort overrides every other transition, including samp_done and handshakes.
  always_comb begin
    fsm_nxt = fsm_q;
    case (fsm_q)
      S_IDLE:      if (sel) fsm_nxt = S_ARM;
      S_ARM:       fsm_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (samp_done) fsm_nxt = S_FETCH;
      S_FETCH:     fsm_nxt = S_LOAD;
      S_LOAD:      fsm_nxt = S_PRESENT;
      S_PRESENT:   if (hs) fsm_nxt = tx_last ? S_FINISH : S_FETCH;
      S_FINISH:    fsm_nxt = S_IDLE;
      default:     fsm_nxt = S_IDLE;
    endcase
    if (abort && (fsm_q != S_IDLE)) fsm_nxt = S_IDLE;
  end

  // Outputs are registered from the next state so each asserts in its own state's cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      arm      <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ptr      <= '0;
      cnt      <= '0;
    end else begin
      fsm_q    <= fsm_nxt;
      arm      <= (fsm_nxt == S_ARM);
      rd_en    <= (fsm_nxt == S_FETCH);
      tx_valid <= (fsm_nxt == S_PRESENT);
      busy     <= (fsm_nxt != S_IDLE);
      done     <= (fsm_nxt == S_FINISH);

      if ((fsm_q == S_WAIT_DONE) && (fsm_nxt == S_FETCH)) begin
        ptr     <= trig_addr - PRE_OFS;
        rd_addr <= trig_addr - PRE_OFS;
        cnt     <= '0;
      end

      if ((fsm_q == S_PRESENT) && (fsm_nxt == S_FETCH)) begin
        ptr     <= ptr + 1'b1;
        rd_addr <= ptr + 1'b1;
        cnt     <= cnt + 1'b1;
      end

      if ((fsm_q == S_LOAD) && (fsm_nxt == S_PRESENT)) begin
        tx_data <= rd_data;
        tx_last <= (cnt == LAST_CNT);
      end else if (fsm_nxt != S_PRESENT) begin
        tx_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: scoreboard of expected read addresses and
// bytes filled when samp_done is driven, drained as the DUT fetches and transmits.
module tb_capture_ctrl;

  localparam int         AW    = 10;
  localparam int         DEPTH = 1024;
  localparam int         PRE   = 512;
  localparam logic [7:0] MID   = 8'h10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    state;
  logic          state_change;
  logic          arm;
  logic          samp_done;
  logic [AW-1:0] trig_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_last;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [DEPTH];
  int         exp_addr_q[$];
  logic [8:0] exp_data_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  capture_ctrl #(
    .MODULE_ID  (MID),
    .ADDR_W     (AW),
    .PRE_SAMPLES(PRE),
    .DATA_W     (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state),
    .state_change(state_change),
    .arm         (arm),
    .samp_done   (samp_done),
    .trig_addr   (trig_addr),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .busy        (busy),
    .done        (done)
  );

  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    state        = v;
    state_change = 1'b1;
    @(negedge clk);
    state_change = 1'b0;
  endtask

  task automatic do_select(input string tag);
    strobe(MID);
    total++;
    if (arm !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s select: arm=%b busy=%b, want arm=1 busy=1", tag, arm, busy);
    end
    @(negedge clk);
    total++;
    if (arm !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s arm_once: arm=%b busy=%b, want arm=0 busy=1", tag, arm, busy);
    end
  endtask

  task automatic do_samp(input int trig, input string tag, output int first);
    int a;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      a = (trig + DEPTH - PRE + k) % DEPTH;
      exp_addr_q.push_back(a);
      exp_data_q.push_back({(k == DEPTH - 1), mem[a]});
    end
    @(negedge clk);
    samp_done = 1'b1;
    trig_addr = AW'(trig);
    @(negedge clk);
    samp_done = 1'b0;
    first     = int'(rd_addr);
    total++;
    if (rd_en !== 1'b1 || rd_addr !== AW'(exp_addr_q[0])) begin
      bad++;
      $display("FAIL %s first_fetch: rd_en=%b rd_addr=%0d, want rd_en=1 rd_addr=%0d",
               tag, rd_en, rd_addr, exp_addr_q[0]);
    end
    void'(exp_addr_q.pop_front());
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    tx_ready = 1'b0;
    while (tx_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tx_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s wait_valid: tx_valid=%b after %0d cycles, want 1", tag, tx_valid, n);
    end
  endtask

  // mode 0: always ready; mode 1: random ready plus a 20-cycle stall after byte 300.
  task automatic drain(input int mode, input bit inject, input string tag);
    int         nbytes   = 0;
    int         cyc      = 0;
    int         low_left = 0;
    bit         low_done = 1'b0;
    bit         stall    = 1'b0;
    bit         got_last = 1'b0;
    bit         injected = 1'b0;
    logic [7:0] pdata    = 8'h00;
    logic       plast    = 1'b0;
    logic       rdy;
    logic [8:0] e;
    while (!got_last && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      state_change = 1'b0;
      if (rd_en === 1'b1) begin
        total++;
        if (exp_addr_q.size() == 0) begin
          bad++;
          $display("FAIL %s rd_addr: got %0d, want no further fetch", tag, rd_addr);
        end else begin
          if (rd_addr !== AW'(exp_addr_q[0])) begin
            bad++;
            $display("FAIL %s rd_addr: got %0d want %0d", tag, rd_addr, exp_addr_q[0]);
          end
          void'(exp_addr_q.pop_front());
        end
      end
      if (stall) begin
        total++;
        if (tx_valid !== 1'b1 || tx_data !== pdata || tx_last !== plast) begin
          bad++;
          $display("FAIL %s stall_hold: valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                   tag, tx_valid, tx_data, tx_last, pdata, plast);
        end
      end
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL %s early_done: done=%b at byte %0d, want 0", tag, done, nbytes);
      end
      if (mode == 0) begin
        rdy = 1'b1;
      end else begin
        if (!low_done && nbytes >= 300) begin
          low_left = 20;
          low_done = 1'b1;
        end
        if (low_left > 0) begin
          rdy = 1'b0;
          low_left--;
        end else begin
          rdy = ($urandom_range(0, 2) != 0);
        end
      end
      tx_ready = rdy;
      if (tx_valid === 1'b1 && rdy) begin
        e = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 9'bx;
        total++;
        if ({tx_last, tx_data} !== e) begin
          bad++;
          $display("FAIL %s byte%0d: last=%b data=%h, want last=%b data=%h",
                   tag, nbytes, tx_last, tx_data, e[8], e[7:0]);
        end
        nbytes++;
        if (tx_last === 1'b1) got_last = 1'b1;
      end
      stall = (tx_valid === 1'b1) && !rdy;
      pdata = tx_data;
      plast = tx_last;
      if (inject && !injected && nbytes == 100) begin
        state        = MID;
        state_change = 1'b1;
        injected     = 1'b1;
      end
    end
    total++;
    if (!got_last) begin
      bad++;
      $display("FAIL %s timeout: %0d bytes in %0d cycles, want tx_last", tag, nbytes, cyc);
    end
    total++;
    if (nbytes != DEPTH) begin
      bad++;
      $display("FAIL %s byte_count: got %0d want %0d", tag, nbytes, DEPTH);
    end
    @(negedge clk);
    state_change = 1'b0;
    tx_ready     = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || tx_valid !== 1'b0 || tx_last !== 1'b0) begin
      bad++;
      $display("FAIL %s finish: done=%b busy=%b valid=%b last=%b, want 1 1 0 0",
               tag, done, busy, tx_valid, tx_last);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s to_idle: done=%b busy=%b, want 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({arm, rd_en, rd_addr, tx_data, tx_valid, tx_last, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_state: outputs=%h, want 0",
               {arm, rd_en, rd_addr, tx_data, tx_valid, tx_last, busy, done});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({arm, rd_en, tx_valid, tx_last, busy, done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_release: ctrl=%b, want 000000", {arm, rd_en, tx_valid, tx_last, busy, done});
    end
  endtask

  task automatic test_basic;
    int first;
    do_select("basic");
    do_samp(600, "basic", first);
    total++;
    if (first != 88) begin
      bad++;
      $display("FAIL basic start_addr: got %0d want 88", first);
    end
    drain(0, 1'b0, "basic");
  endtask

  task automatic test_wrap;
    int first;
    do_select("wrap");
    do_samp(100, "wrap", first);
    total++;
    if (first != 612) begin
      bad++;
      $display("FAIL wrap start_addr: got %0d want 612", first);
    end
    total++;
    if (exp_data_q[PRE][7:0] !== mem[100]) begin
      bad++;
      $display("FAIL wrap trigger_index: byte %0d holds %h, want %h", PRE, exp_data_q[PRE][7:0], mem[100]);
    end
    drain(0, 1'b0, "wrap");
  endtask

  task automatic test_backpressure;
    int first;
    do_select("bp");
    do_samp(900, "bp", first);
    drain(1, 1'b0, "bp");
  endtask

  task automatic test_abort;
    int first;
    do_select("abort");
    do_samp(300, "abort", first);
    wait_valid("abort");
    strobe(8'h20);
    total++;
    if ({arm, rd_en, tx_valid, tx_last, busy, done} !== 6'b0) begin
      bad++;
      $display("FAIL abort_idle: arm,rd_en,valid,last,busy,done=%b, want 000000",
               {arm, rd_en, tx_valid, tx_last, busy, done});
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: done=%b busy=%b, want 0 0", done, busy);
    end
    do_select("rearm");
    do_samp(5, "rearm", first);
    drain(0, 1'b0, "rearm");
  endtask

  task automatic test_collisions;
    int first;
    do_select("coll");
    @(negedge clk);
    samp_done    = 1'b1;
    trig_addr    = AW'(600);
    state        = 8'h20;
    state_change = 1'b1;
    @(negedge clk);
    samp_done    = 1'b0;
    state_change = 1'b0;
    total++;
    if (rd_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL coll_abort_wins: rd_en=%b busy=%b, want 0 0", rd_en, busy);
    end
    @(negedge clk);
    total++;
    if (rd_en !== 1'b0 || busy !== 1'b0 || arm !== 1'b0) begin
      bad++;
      $display("FAIL coll_stays_idle: rd_en=%b busy=%b arm=%b, want 0 0 0", rd_en, busy, arm);
    end
    do_select("resel");
    do_samp(1000, "resel", first);
    drain(0, 1'b1, "resel");
  endtask

  task automatic test_async_reset;
    int first;
    do_select("rst_wait");
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({arm, rd_en, rd_addr, tx_data, tx_valid, tx_last, busy, done} !== '0) begin
      bad++;
      $display("FAIL rst_wait_done: outputs=%h, want 0",
               {arm, rd_en, rd_addr, tx_data, tx_valid, tx_last, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_select("rst_pres");
    do_samp(50, "rst_pres", first);
    wait_valid("rst_pres");
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({arm, rd_en, rd_addr, tx_data, tx_valid, tx_last, busy, done} !== '0) begin
      bad++;
      $display("FAIL rst_present: outputs=%h, want 0",
               {arm, rd_en, rd_addr, tx_data, tx_valid, tx_last, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({arm, rd_en, tx_valid, tx_last, busy, done} !== 6'b0) begin
      bad++;
      $display("FAIL rst_release_idle: ctrl=%b, want 000000", {arm, rd_en, tx_valid, tx_last, busy, done});
    end
    do_select("post_rst");
    do_samp(50, "post_rst", first);
    drain(0, 1'b0, "post_rst");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 5));
    state        = 8'h00;
    state_change = 1'b0;
    samp_done    = 1'b0;
    trig_addr    = '0;
    tx_ready     = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_abort();
    test_collisions();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
